// File: rtl/tick_seq_pkg.sv
// Shared types and constants for the tick/phase sequencer: phase encoding,
// the one-hot decode helper and counter widths.
package tick_seq_pkg;

  localparam int DWELL_W     = 8;
  localparam int PRESC_W_DEF = 13;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_t;

  function automatic logic [3:0] onehot4(input phase_t p);
    onehot4 = 4'b0001 << p;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Power-of-two prescaler: emits a combinational terminal-count strobe and a
// registered one-cycle tick one edge later.
module tick_prescaler #(
  parameter int PRESC_W = 13
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic [3:0] i_sel,
  output logic       o_tick_int,
  output logic       o_tick
);

  logic [3:0]         w_s;
  logic [PRESC_W-1:0] w_lim;
  logic [PRESC_W-1:0] r_cnt;
  logic               r_tick;

  assign w_s   = (int'(i_sel) > PRESC_W-1) ? 4'(PRESC_W-1) : i_sel;
  assign w_lim = ~({PRESC_W{1'b1}} << w_s);

  // >= rather than == so a shorter period chosen mid-count wraps at once
  assign o_tick_int = i_run && (r_cnt >= w_lim);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (o_tick_int) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + {{(PRESC_W-1){1'b0}}, i_run};
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/tick_phase_sequencer.sv
// Tick-driven 4-phase sequencer with synchronized manual step input.
// Define SEQ_PINGPONG_EN for PH0..PH3..PH0 ping-pong order instead of circular.
module tick_phase_sequencer
  import tick_seq_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int DWELL0  = 4,
  parameter int DWELL1  = 1,
  parameter int DWELL2  = 3,
  parameter int DWELL3  = 1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       w_clk, w_rst, w_run, w_step;
  logic [3:0] w_sel;

  assign w_clk  = io_in[0];
  assign w_rst  = io_in[1];
  assign w_run  = io_in[2];
  assign w_step = io_in[3];
  assign w_sel  = io_in[7:4];

  logic w_tick_int, w_tick;

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_clk      (w_clk),
    .i_rst      (w_rst),
    .i_run      (w_run),
    .i_sel      (w_sel),
    .o_tick_int (w_tick_int),
    .o_tick     (w_tick)
  );

  // [0],[1]: synchronizer, [2]: previous value for rising-edge detect
  logic [2:0] r_step_sync;
  logic       w_step_p;

  always_ff @(posedge w_clk) begin
    if (w_rst) r_step_sync <= '0;
    else       r_step_sync <= {r_step_sync[1:0], w_step};
  end

  assign w_step_p = r_step_sync[1] & ~r_step_sync[2];

  phase_t             r_phase, w_phase_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt, w_dwell_lim;
  logic [3:0]         r_onehot;
  logic               r_pc, r_hb, w_at_lim, w_adv, w_hb_tgl;
`ifdef SEQ_PINGPONG_EN
  logic               r_dir_up, w_dir_nxt;
`endif

  always_comb begin
    w_dwell_lim = DWELL_W'(DWELL0-1);
    case (r_phase)
      PH1:     w_dwell_lim = DWELL_W'(DWELL1-1);
      PH2:     w_dwell_lim = DWELL_W'(DWELL2-1);
      PH3:     w_dwell_lim = DWELL_W'(DWELL3-1);
      default: w_dwell_lim = DWELL_W'(DWELL0-1);
    endcase
  end

  assign w_at_lim = (r_dwell == w_dwell_lim);
  // a step coinciding with a tick consumes the tick: one advance only
  assign w_adv    = w_step_p | (w_tick_int & w_at_lim);

  always_comb begin
    w_phase_nxt = r_phase;
    w_dwell_nxt = r_dwell;
    w_hb_tgl    = 1'b0;
`ifdef SEQ_PINGPONG_EN
    w_dir_nxt   = r_dir_up;
`endif
    if (w_adv)           w_dwell_nxt = '0;
    else if (w_tick_int) w_dwell_nxt = r_dwell + DWELL_W'(1);
    if (w_adv) begin
`ifdef SEQ_PINGPONG_EN
      if ((r_dir_up && r_phase != PH3) || (!r_dir_up && r_phase == PH0))
        w_phase_nxt = phase_t'(r_phase + 2'd1);
      else
        w_phase_nxt = phase_t'(r_phase - 2'd1);
      if (r_phase == PH3)      w_dir_nxt = 1'b0;
      else if (r_phase == PH0) w_dir_nxt = 1'b1;
      w_hb_tgl = (w_phase_nxt == PH0) || (w_phase_nxt == PH3);
`else
      w_phase_nxt = phase_t'(r_phase + 2'd1);
      w_hb_tgl    = (w_phase_nxt == PH0);
`endif
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_phase  <= PH0;
      r_dwell  <= '0;
      r_onehot <= 4'b0001;
      r_pc     <= 1'b0;
      r_hb     <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      r_dir_up <= 1'b1;
`endif
    end else begin
      r_phase  <= w_phase_nxt;
      r_dwell  <= w_dwell_nxt;
      r_onehot <= onehot4(w_phase_nxt);
      r_pc     <= w_adv;
      r_hb     <= r_hb ^ w_hb_tgl;
`ifdef SEQ_PINGPONG_EN
      r_dir_up <= w_dir_nxt;
`endif
    end
  end

  assign io_out = {r_hb, r_phase[0], r_pc, w_tick, r_onehot};

endmodule

// File: tb/tb_tick_phase_sequencer.sv
// Directed bench for tick_phase_sequencer; expected io_out bytes hand-derived.
// Expectations follow SEQ_PINGPONG_EN when that macro is defined.
module tb_tick_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [7:0] io_in, io_out;
  int n_chk = 0;
  int n_pass = 0;
  int e = 0;

  assign io_in = {sel, step, run, rst, clk};

  tick_phase_sequencer dut (.io_in(io_in), .io_out(io_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic to_edge(input int n);
    while (e < n) begin
      @(posedge clk); #1;
      e++;
    end
  endtask

  // reset edge is E0; inputs applied afterwards take effect from E1
  task automatic do_reset(input logic r, input logic [3:0] s);
    rst = 1'b1; step = 1'b0;
    @(posedge clk); #1;
    e = 0;
    rst = 1'b0; run = r; sel = s;
  endtask

  initial begin
    // circular defaults, sel=2
    do_reset(1'b1, 4'd2);
    chk("reset_state", io_out, 8'h01);
    to_edge(3);  chk("c_no_tick_e3", io_out, 8'h01);
    to_edge(4);  chk("c_tick_e4", io_out, 8'h11);
    to_edge(5);  chk("c_tick_low_e5", io_out, 8'h01);
    to_edge(16); chk("c_ph1_e16", io_out, 8'h72);
    to_edge(17); chk("c_ph1_hold", io_out, 8'h42);
    to_edge(20); chk("c_ph2_e20", io_out, 8'h34);
`ifdef SEQ_PINGPONG_EN
    to_edge(32); chk("c_ph3_e32", io_out, 8'hF8);
    to_edge(36); chk("c_back_ph2", io_out, 8'hB4);
`else
    to_edge(32); chk("c_ph3_e32", io_out, 8'h78);
    to_edge(36); chk("c_wrap_hb", io_out, 8'hB1);
`endif

    // sel=0: tick every cycle
    do_reset(1'b1, 4'd0);
    to_edge(1);  chk("s0_tick_e1", io_out, 8'h11);
    to_edge(4);  chk("s0_ph1_e4", io_out, 8'h72);
`ifdef SEQ_PINGPONG_EN
    to_edge(8);  chk("s0_ph3_e8", io_out, 8'hF8);
    to_edge(9);  chk("s0_ph2_e9", io_out, 8'hB4);
    to_edge(18); chk("s0_e18", io_out, 8'h34);
`else
    to_edge(8);  chk("s0_ph3_e8", io_out, 8'h78);
    to_edge(9);  chk("s0_wrap_e9", io_out, 8'hB1);
    to_edge(18); chk("s0_wrap_e18", io_out, 8'h31);
`endif

    // run=0, manual step held 5 cycles
    do_reset(1'b0, 4'd2);
    step = 1'b1;
    to_edge(2);  chk("st_before", io_out, 8'h01);
    to_edge(3);  chk("st_adv_e3", io_out, 8'h62);
    to_edge(5);  chk("st_single", io_out, 8'h42);
    step = 1'b0;
    to_edge(8);
    step = 1'b1;
    to_edge(10); chk("st2_before", io_out, 8'h42);
    to_edge(11); chk("st2_ph2", io_out, 8'h24);
    step = 1'b0;

    // sel=12 then drop to sel=3 at cnt=2000
    do_reset(1'b1, 4'd12);
    to_edge(2000); chk("sd_no_tick", {7'd0, io_out[4]}, 8'h00);
    sel = 4'd3;
    to_edge(2001); chk("sd_tick_now", {7'd0, io_out[4]}, 8'h01);
    to_edge(2002); chk("sd_tick_low", {7'd0, io_out[4]}, 8'h00);
    to_edge(2008); chk("sd_pre_8", {7'd0, io_out[4]}, 8'h00);
    to_edge(2009); chk("sd_tick_8", {7'd0, io_out[4]}, 8'h01);

    // step_p coincides with the 4th PH0 tick
    do_reset(1'b1, 4'd2);
    to_edge(13);
    step = 1'b1;
    to_edge(15); chk("co_before", io_out, 8'h01);
    to_edge(16); chk("co_one_adv", io_out, 8'h72);
    to_edge(17); chk("co_hold", io_out, 8'h42);
    to_edge(20); chk("co_dwell0", io_out, 8'h34);
    step = 1'b0;

    // reset mid-PH2 with cnt=2
    to_edge(22);
    rst = 1'b1;
    to_edge(23); chk("mid_reset", io_out, 8'h01);
    rst = 1'b0;
    to_edge(24); chk("post_reset", io_out, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
